alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
Multi-byte operation sequencer for the team's 8-bit combinational ALU (3-bit oper; a, b, c_in; sum, c_out). Accepts one NBYTES-wide operation through a start/ready handshake and drives the external ALU one byte per cycle, LSB first, chaining the carry between bytes. Returns the assembled result, final carry and zero flag with a one-cycle done pulse. Sits between the datapath control and a single shared ALU instance.

Parameters:
NBYTES, 4, operand/result width in bytes (>=2); data width W = 8*NBYTES

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request; accepted on a rising edge when ready=1
op  input  3  ALU opcode for the whole operation
opa  input  W  operand A
opb  input  W  operand B
cin  input  1  carry-in for the first byte
ready  output  1  idle, can accept start
busy  output  1  operation in progress (RUN or DONE)
done  output  1  one-cycle pulse: result/cout/zero valid
result  output  W  assembled result, held until next accept
cout  output  1  final carry
zero  output  1  result == 0
alu_oper  output  3  to ALU oper
alu_a  output  8  to ALU a
alu_b  output  8  to ALU b
alu_cin  output  1  to ALU c_in
alu_sum  input  8  from ALU sum
alu_cout  input  1  from ALU c_out

Behaviour:
- Single clock clk; reset rst_n is asynchronous, active-low. Reset: state IDLE, byte index 0, result 0, cout 0, zero 0, done 0, ready 1, busy 0, latched op/operands/cin 0.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE: ready=1. Edge with start=1: latch op, opa, opb, cin; index=0; go RUN. start=0: stay.
- RUN: ALU outputs combinational from latched values: alu_oper=op, alu_a/alu_b = byte[index] of latched A/B. Each edge: result byte[index] <= alu_sum, carry register <= alu_cout, index++. Edge with index=NBYTES-1 -> DONE, cout <= alu_cout of that byte (0 for logic ops).
- alu_cin: index 0 -> latched cin; later bytes: op 000/001 -> previous alu_cout; op 010 -> inverted previous alu_cout (the ALU inverts c_in for this opcode); ops 011-111 -> 0.
- op 010 first-byte convention: cin=0 gives plain b-a (ALU applies ~c_in).
- DONE: done=1 for exactly one cycle; zero=(result==0) valid; next edge -> IDLE.
- Outside RUN: alu_a=alu_b=0, alu_cin=0, alu_oper=latched op.
- Latency: done high in the cycle after the NBYTES-th RUN edge, i.e. NBYTES cycles after the accept edge; ready again NBYTES+1 cycles after accept. Back-to-back: start held high is accepted on the first edge in IDLE.
- start during RUN/DONE ignored, no effect on latched values. Operand inputs may change after accept.
- result/cout/zero hold from DONE until the next accept edge, then are overwritten byte-wise during RUN (result not valid until done).
- rst_n low mid-operation: immediate return to reset values; no done pulse for the aborted op.
- ALU carry assumed combinational within one cycle; no other timing dependence.

Test Plan:
1. NBYTES=4, op=000, opa=0x000000FF, opb=0x00000001, cin=0 -> done 4 cycles after accept, result=0x00000100, cout=0, zero=0; ready back next cycle.
2. op=000, opa=0xFFFFFFFF, opb=0x00000001, cin=0 -> result=0x00000000, cout=1, zero=1; alu_cin=1 on bytes 1..3.
3. op=001, opa=0x00000100, opb=0x00000001, cin=1 -> result=0x000000FF, cout=1 (no borrow).
4. op=010, opa=0x00000005, opb=0x00000003, cin=0 -> result=0xFFFFFFFE, cout=0; alu_cin=1 on bytes 1..3.
5. op=110, opa=0xF0F0F0F0, opb=0xFFFF0000, start pulsed again during RUN with other operands -> single done, result=0x0F0FF0F0, cout=0; second start ignored.
6. Start op=000, assert rst_n=0 after 2 RUN edges -> outputs at reset values immediately, no done; new op after release completes correctly.

Source files
------------

// File: rtl/alu_seq_ctrl_if.sv
// alu_seq_ctrl_if: request/result handshake between datapath control and the multi-byte ALU sequencer
interface alu_seq_ctrl_if #(parameter int W = 32);
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic         cin;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         zero;
  modport master (output start, op, opa, opb, cin, input ready, busy, done, result, cout, zero);
  modport slave (input start, op, opa, opb, cin, output ready, busy, done, result, cout, zero);
endinterface

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: drives a shared 8-bit ALU one byte per cycle, LSB first, to run an NBYTES-wide operation
module alu_seq_ctrl #(parameter int NBYTES = 4) (
  input  logic         clk,
  input  logic         rst_n,
  alu_seq_ctrl_if.slave bus,
  output logic [2:0]   alu_oper,
  output logic [7:0]   alu_a,
  output logic [7:0]   alu_b,
  output logic         alu_cin,
  input  logic [7:0]   alu_sum,
  input  logic         alu_cout
);
  localparam int W = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [IW-1:0] idx;
  logic [2:0] op_q;
  logic [W-1:0] a_q, b_q, res_nx;
  logic cin_q, carry_q, last, run;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = bus.start ? RUN : IDLE;
      RUN: state_nx = last ? DONE : RUN;
      default: state_nx = IDLE;
    endcase
  end
  assign run = state == RUN;
  assign last = idx == LAST;
  assign bus.ready = state == IDLE;
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  assign alu_oper = op_q;
  assign alu_a = run ? a_q[{idx, 3'b000} +: 8] : 8'h00;
  assign alu_b = run ? b_q[{idx, 3'b000} +: 8] : 8'h00;
  // op 010: the ALU inverts c_in, so the chained carry is passed inverted
  assign alu_cin = !run ? 1'b0 : idx == '0 ? cin_q : op_q[2:1] == 2'b00 ? carry_q :
                   op_q == 3'b010 ? ~carry_q : 1'b0;
  always_comb begin
    res_nx = bus.result;
    res_nx[{idx, 3'b000} +: 8] = alu_sum;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx <= '0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      cin_q <= 1'b0;
      carry_q <= 1'b0;
      bus.result <= '0;
      bus.cout <= 1'b0;
      bus.zero <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      idx <= '0;
      op_q <= bus.op;
      a_q <= bus.opa;
      b_q <= bus.opb;
      cin_q <= bus.cin;
    end else if (run) begin
      bus.result <= res_nx;
      carry_q <= alu_cout;
      idx <= last ? '0 : idx + 1'b1;
      if (last) begin
        bus.cout <= alu_cout;
        bus.zero <= res_nx == '0;
      end
    end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: table vectors, hand sequences and random ops against a word-level reference model
module tb_alu_seq_ctrl;
  localparam int NB = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] alu_oper;
  logic [7:0] alu_a, alu_b, alu_sum;
  logic alu_cin, alu_cout;
  int errors = 0;
  int checks = 0;
  alu_seq_ctrl_if #(.W(32)) bus();
  alu_seq_ctrl #(.NBYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .alu_oper(alu_oper), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_sum(alu_sum), .alu_cout(alu_cout)
  );
  always #5 clk = ~clk;
  // External 8-bit ALU: 000 add, 001 a-b, 010 b-a with inverted c_in, 011 and, 100 or, 101 not a, 110 xor, 111 pass b
  always_comb begin
    logic [8:0] t;
    logic [7:0] na, nb;
    na = ~alu_a;
    nb = ~alu_b;
    t = 9'h000;
    case (alu_oper)
      3'b000: t = 9'(alu_a) + 9'(alu_b) + 9'(alu_cin);
      3'b001: t = 9'(alu_a) + 9'(nb) + 9'(alu_cin);
      3'b010: t = 9'(alu_b) + 9'(na) + 9'(!alu_cin);
      3'b011: t = {1'b0, alu_a & alu_b};
      3'b100: t = {1'b0, alu_a | alu_b};
      3'b101: t = {1'b0, na};
      3'b110: t = {1'b0, alu_a ^ alu_b};
      default: t = {1'b0, alu_b};
    endcase
    alu_sum = t[7:0];
    alu_cout = t[8];
  end
  function automatic logic [32:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic c);
    logic [31:0] na, nb;
    na = ~a;
    nb = ~b;
    case (op)
      3'b000: return 33'(a) + 33'(b) + 33'(c);
      3'b001: return 33'(a) + 33'(nb) + 33'(c);
      3'b010: return 33'(b) + 33'(na) + 33'(!c);
      3'b011: return {1'b0, a & b};
      3'b100: return {1'b0, a | b};
      3'b101: return {1'b0, na};
      3'b110: return {1'b0, a ^ b};
      default: return {1'b0, b};
    endcase
  endfunction
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic c,
                        input bit poke, input bit hold, output logic [31:0] r, output logic co, output logic z,
                        output int lat, output int wt, output logic [3:0] cins);
    bus.start = 1'b1;
    bus.op = op;
    bus.opa = a;
    bus.opb = b;
    bus.cin = c;
    wt = 0;
    while (!bus.ready && wt < 20) begin
      @(posedge clk);
      #1;
      wt++;
    end
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
    bus.op = 3'($urandom);
    bus.opa = $urandom;
    bus.opb = $urandom;
    bus.cin = 1'($urandom);
    lat = 0;
    cins = '0;
    while (!bus.done && lat < 20) begin
      if (lat < NB) cins[lat] = alu_cin;
      if (poke && lat == 1) bus.start = 1'b1;
      @(posedge clk);
      #1;
      if (poke) bus.start = 1'b0;
      lat++;
    end
    r = bus.result;
    co = bus.cout;
    z = bus.zero;
  endtask
  typedef struct {
    logic [2:0] op;
    logic [31:0] a, b;
    logic cin;
    bit poke;
    logic [31:0] res;
    logic cout, zero;
    logic [3:0] cins;
  } vec_t;
  vec_t tv[5];
  initial begin
    logic [31:0] r;
    logic co, z;
    logic [3:0] cins;
    logic [32:0] m;
    int lat, wt;
    logic [2:0] op;
    logic [31:0] a, b;
    logic c;
    bit seen;
    tv[0] = '{3'b000, 32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 4'b0010};
    tv[1] = '{3'b000, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 4'b1110};
    tv[2] = '{3'b001, 32'h00000100, 32'h00000001, 1'b1, 1'b0, 32'h000000FF, 1'b1, 1'b0, 4'b1101};
    tv[3] = '{3'b010, 32'h00000005, 32'h00000003, 1'b0, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 4'b1110};
    tv[4] = '{3'b110, 32'hF0F0F0F0, 32'hFFFF0000, 1'b0, 1'b1, 32'h0F0FF0F0, 1'b0, 1'b0, 4'b0000};
    bus.start = 1'b0;
    bus.op = 3'b111;
    bus.opa = 32'hDEADBEEF;
    bus.opb = 32'h12345678;
    bus.cin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", bus.ready, 1);
    chk("reset busy", bus.busy, 0);
    chk("reset done", bus.done, 0);
    chk("reset result/cout/zero", {bus.result, bus.cout, bus.zero}, 0);
    chk("reset alu outputs", {alu_oper, alu_a, alu_b, alu_cin}, 0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle no start", {bus.ready, bus.busy}, 2'b10);
    foreach (tv[i]) begin
      run_op(tv[i].op, tv[i].a, tv[i].b, tv[i].cin, tv[i].poke, 1'b0, r, co, z, lat, wt, cins);
      chk($sformatf("vec%0d latency", i), lat, NB);
      chk($sformatf("vec%0d result", i), r, tv[i].res);
      chk($sformatf("vec%0d cout", i), co, tv[i].cout);
      chk($sformatf("vec%0d zero", i), z, tv[i].zero);
      chk($sformatf("vec%0d alu_cin per byte", i), cins, tv[i].cins);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d ready after done", i), {bus.ready, bus.done}, 2'b10);
      chk($sformatf("vec%0d result held", i), bus.result, tv[i].res);
      if (tv[i].poke) begin
        seen = 1'b0;
        repeat (6) begin
          @(posedge clk);
          #1;
          seen |= bus.done | bus.busy;
        end
        chk("poke no second op", seen, 0);
      end
    end
    run_op(3'b000, 32'h11111111, 32'h22222222, 1'b0, 1'b0, 1'b1, r, co, z, lat, wt, cins);
    chk("b2b first result", r, 32'h33333333);
    run_op(3'b001, 32'h00000000, 32'h00000001, 1'b1, 1'b0, 1'b0, r, co, z, lat, wt, cins);
    chk("b2b ready wait", wt, 1);
    chk("b2b second latency", lat, NB);
    chk("b2b second result", {co, r}, {1'b0, 32'hFFFFFFFF});
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.op = 3'b000;
    bus.opa = 32'hFFFFFFFF;
    bus.opb = 32'h00000001;
    bus.cin = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort ready/busy/done", {bus.ready, bus.busy, bus.done}, 3'b100);
    chk("abort result/cout/zero", {bus.result, bus.cout, bus.zero}, 0);
    chk("abort alu outputs", {alu_oper, alu_a, alu_b, alu_cin}, 0);
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      seen |= bus.done;
    end
    chk("abort no done", seen, 0);
    #2 rst_n = 1'b1;
    run_op(3'b000, 32'h0000FFFF, 32'h00000001, 1'b1, 1'b0, 1'b0, r, co, z, lat, wt, cins);
    chk("post-reset latency", lat, NB);
    chk("post-reset result", {co, z, r}, {2'b00, 32'h00010001});
    for (int k = 0; k < 40; k++) begin
      op = 3'($urandom);
      a = (k % 5 == 0) ? 32'hFFFFFFFF : $urandom;
      b = (k % 7 == 0) ? ~a + 32'(k % 2) : $urandom;
      c = 1'($urandom);
      m = ref_op(op, a, b, c);
      run_op(op, a, b, c, 1'($urandom), 1'b0, r, co, z, lat, wt, cins);
      chk($sformatf("rand%0d op%0d latency", k, op), lat, NB);
      chk($sformatf("rand%0d op%0d {cout,zero,result}", k, op), {co, z, r}, {m[32], m[31:0] == 0, m[31:0]});
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
